// File: rtl/data_ram_pkg.sv
// Shared types and helpers for the data-memory responder: FSM encoding, word geometry,
// and address decode functions.
package data_ram_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned CNT_W      = 4;

    function automatic logic [31:0] word_index(input logic [31:0] addr);
        return addr >> $clog2(WORD_BYTES);
    endfunction

    // Any address bit above the array span makes the access out of range.
    function automatic logic in_range(input logic [31:0] addr, input int unsigned depth_log2);
        logic [31:0] hi;
        hi = addr >> (depth_log2 + $clog2(WORD_BYTES));
        return hi == 32'd0;
    endfunction

endpackage

// File: rtl/data_ram_if.sv
// Load/store port between the CPU (master) and the data RAM (slave).
interface data_ram_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output ce, we, addr, sel, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  ce, we, addr, sel, wdata,
        output rdata, ready, err
    );
endinterface

// File: rtl/ram_bytelane_array.sv
// Four byte-wide arrays with per-lane synchronous write and a shared synchronous read port.
module ram_bytelane_array
    import data_ram_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DEPTH_LOG2-1:0] idx_i,
    input  logic [3:0]            we_i,
    input  logic [31:0]           wdata_i,
    input  logic                  re_i,
    output logic [31:0]           rdata_o
);
    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    for (genvar g = 0; g < WORD_BYTES; g++) begin : g_lane
        logic [7:0] mem [Depth];
        logic [7:0] rdata_d;
        logic [7:0] rdata_q;

        always_ff @(posedge clock) begin
            if (we_i[g]) begin
                mem[idx_i] <= wdata_i[8*g +: 8];
            end
        end

        // Read register holds zero except in the cycle after a read strobe.
        always_comb begin
            rdata_d = 8'h00;
            if (re_i) begin
                rdata_d = mem[idx_i];
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                rdata_q <= 8'h00;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign rdata_o[8*g +: 8] = rdata_q;
    end

endmodule

// File: rtl/data_ram.sv
// Data-memory responder: accepts one word request at a time, waits WAIT_CYCLES, then performs
// the access and pulses ready for one cycle.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic       clock,
    input logic       reset,
    data_ram_if.slave io_ram
);
    localparam logic [CNT_W-1:0] WaitInit = CNT_W'(WAIT_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       sel_q, sel_d;
    logic             we_q, we_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             enter_resp;

    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic [3:0]            req_sel;
    logic                  req_we;
    logic                  req_ok;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic [3:0]            lane_we;
    logic                  lane_re;

    // With zero wait states the access happens on the accepting edge, so the live bus is used.
    always_comb begin
        if (state_q == StIdle) begin
            req_addr  = io_ram.addr;
            req_wdata = io_ram.wdata;
            req_sel   = io_ram.sel;
            req_we    = io_ram.we;
        end else begin
            req_addr  = addr_q;
            req_wdata = wdata_q;
            req_sel   = sel_q;
            req_we    = we_q;
        end
        req_idx = DEPTH_LOG2'(word_index(req_addr));
        req_ok  = in_range(req_addr, DEPTH_LOG2);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        we_d       = we_q;
        enter_resp = 1'b0;
        case (state_q)
            StIdle: begin
                if (io_ram.ce) begin
                    addr_d  = io_ram.addr;
                    wdata_d = io_ram.wdata;
                    sel_d   = io_ram.sel;
                    we_d    = io_ram.we;
                    cnt_d   = WaitInit;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        ready_d = enter_resp;
        err_d   = enter_resp && !req_ok;
    end

    assign lane_we = {4{enter_resp && req_we && req_ok}} & req_sel;
    assign lane_re = enter_resp && !req_we && req_ok;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    ram_bytelane_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clock  (clock),
        .reset  (reset),
        .idx_i  (req_idx),
        .we_i   (lane_we),
        .wdata_i(req_wdata),
        .re_i   (lane_re),
        .rdata_o(io_ram.rdata)
    );

    assign io_ram.ready = ready_q;
    assign io_ram.err   = err_q;

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: three instances (0, 1 and 3 wait states) checked against a word-array model.
module tb_data_ram;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    data_ram_if bus0 ();
    data_ram_if bus1 ();
    data_ram_if bus3 ();

    logic        ce_t    [3];
    logic        we_t    [3];
    logic [31:0] addr_t  [3];
    logic [3:0]  sel_t   [3];
    logic [31:0] wdata_t [3];
    logic [31:0] rdata_o [3];
    logic        ready_o [3];
    logic        err_o   [3];

    assign bus0.ce = ce_t[0]; assign bus0.we = we_t[0]; assign bus0.addr = addr_t[0];
    assign bus0.sel = sel_t[0]; assign bus0.wdata = wdata_t[0];
    assign bus1.ce = ce_t[1]; assign bus1.we = we_t[1]; assign bus1.addr = addr_t[1];
    assign bus1.sel = sel_t[1]; assign bus1.wdata = wdata_t[1];
    assign bus3.ce = ce_t[2]; assign bus3.we = we_t[2]; assign bus3.addr = addr_t[2];
    assign bus3.sel = sel_t[2]; assign bus3.wdata = wdata_t[2];
    assign rdata_o[0] = bus0.rdata; assign ready_o[0] = bus0.ready; assign err_o[0] = bus0.err;
    assign rdata_o[1] = bus1.rdata; assign ready_o[1] = bus1.ready; assign err_o[1] = bus1.err;
    assign rdata_o[2] = bus3.rdata; assign ready_o[2] = bus3.ready; assign err_o[2] = bus3.err;

    data_ram #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (.clock(clock), .reset(reset), .io_ram(bus0));
    data_ram #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) u_dut1 (.clock(clock), .reset(reset), .io_ram(bus1));
    data_ram #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_dut3 (.clock(clock), .reset(reset), .io_ram(bus3));

    int waits [3] = '{0, 1, 3};
    logic [31:0] model [3][1024];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic scramble(input int d);
        we_t[d]    = 1'($urandom);
        addr_t[d]  = $urandom;
        sel_t[d]   = 4'($urandom);
        wdata_t[d] = $urandom;
    endtask

    // One complete transaction; drop_at > 0 drops ce and garbles the bus that many cycles in.
    task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wdata,
                          input int drop_at, input string tag);
        int cyc;
        bit seen;
        int idx;
        logic exp_err;
        logic [31:0] exp_rd;
        exp_err = (addr >> 12) != 32'd0;
        idx     = int'(addr[11:2]);
        exp_rd  = (exp_err || we) ? 32'h0 : model[d][idx];
        if (!exp_err && we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) model[d][idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        @(negedge clock);
        ce_t[d] = 1'b1; we_t[d] = we; addr_t[d] = addr; sel_t[d] = sel; wdata_t[d] = wdata;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (cyc == drop_at) begin
                ce_t[d] = 1'b0;
                scramble(d);
            end
            if (ready_o[d] === 1'b1) seen = 1'b1;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(waits[d] + 1));
        check({tag, "_rdata"}, rdata_o[d], exp_rd);
        check({tag, "_err"}, 32'(err_o[d]), 32'(exp_err));
        ce_t[d] = 1'b0;
        scramble(d);
        @(negedge clock);
        check({tag, "_ready_pulse"}, 32'(ready_o[d]), 32'h0);
        check({tag, "_err_idle"}, 32'(err_o[d]), 32'h0);
    endtask

    initial begin
        // T1: reset held with requests pending
        for (int d = 0; d < 3; d++) begin
            ce_t[d] = 1'b1;
            scramble(d);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            for (int d = 0; d < 3; d++) begin
                check("t1_ready", 32'(ready_o[d]), 32'h0);
                check("t1_err", 32'(err_o[d]), 32'h0);
                check("t1_rdata", rdata_o[d], 32'h0);
            end
        end
        for (int d = 0; d < 3; d++) ce_t[d] = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            for (int d = 0; d < 3; d++) check("t1_idle_ready", 32'(ready_o[d]), 32'h0);
        end

        // T2: write then read back, one wait state
        do_req(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, "t2_wr");
        do_req(1, 1'b0, 32'h10, 4'h0, 32'h0, 0, "t2_rd");

        // T3: partial lane write
        do_req(1, 1'b1, 32'h20, 4'hF, 32'h11223344, 0, "t3_pre");
        do_req(1, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 0, "t3_wr");
        do_req(1, 1'b0, 32'h20, 4'hF, 32'h0, 0, "t3_rd");

        // T4: out of range must not alias onto word 0
        do_req(1, 1'b1, 32'h0, 4'hF, 32'h0BADF00D, 0, "t4_pre");
        do_req(1, 1'b0, 32'h1000, 4'hF, 32'h0, 0, "t4_rd_oor");
        do_req(1, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 0, "t4_wr_oor");
        do_req(1, 1'b0, 32'h0, 4'hF, 32'h0, 0, "t4_rd0");
        do_req(1, 1'b1, 32'h24, 4'h0, 32'h55555555, 0, "t4_sel0");

        // T5: ce dropped during WAIT, three wait states
        do_req(2, 1'b1, 32'h04, 4'hF, 32'h12345678, 1, "t5_wr");
        do_req(2, 1'b0, 32'h04, 4'hF, 32'h0, 0, "t5_rd");

        // T6a: reset during WAIT discards the pending write
        do_req(2, 1'b1, 32'h08, 4'hF, 32'h5A5A5A5A, 0, "t6_pre");
        @(negedge clock);
        ce_t[2] = 1'b1; we_t[2] = 1'b1; addr_t[2] = 32'h08; sel_t[2] = 4'hF;
        wdata_t[2] = 32'hCAFEF00D;
        @(negedge clock);
        reset   = 1'b0;
        ce_t[2] = 1'b0;
        #1;
        check("t6_wait_ready", 32'(ready_o[2]), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        do_req(2, 1'b0, 32'h08, 4'hF, 32'h0, 0, "t6_rd");

        // T6b: reset during RESP clears ready and rdata at once
        @(negedge clock);
        ce_t[1] = 1'b1; we_t[1] = 1'b0; addr_t[1] = 32'h10; sel_t[1] = 4'hF;
        @(negedge clock);
        @(negedge clock);
        ce_t[1] = 1'b0;
        check("t6_resp_ready", 32'(ready_o[1]), 32'h1);
        check("t6_resp_rdata", rdata_o[1], model[1][4]);
        reset = 1'b0;
        #1;
        check("t6_abort_ready", 32'(ready_o[1]), 32'h0);
        check("t6_abort_rdata", rdata_o[1], 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // T6c: zero wait states
        do_req(0, 1'b1, 32'h30, 4'hF, 32'h600DCAFE, 0, "t6_w0_wr");
        do_req(0, 1'b0, 32'h30, 4'hF, 32'h0, 0, "t6_w0_rd");

        // Randomized traffic on every instance
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 16; i++) begin
                do_req(d, 1'b1, 32'h40 + 32'(i * 4), 4'hF, $urandom, 0, "rnd_pre");
            end
            for (int i = 0; i < 30; i++) begin
                logic [31:0] a;
                a = 32'h40 + 32'($urandom_range(0, 63));
                if ($urandom_range(0, 7) == 0) a = $urandom | 32'h1000;
                do_req(d, 1'($urandom), a, 4'($urandom), $urandom,
                       ($urandom_range(0, 1) == 1) ? 1 : 0, "rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
